// File: rtl/acia_pkg.sv
// Shared definitions for the ACIA transmitter: FSM states, register map,
// TX-control encodings and baud-rate helpers.
package acia_pkg;

   localparam int unsigned CNT_W = 32;

   localparam logic [1:0] ADDR_TDR  = 2'd0;
   localparam logic [1:0] ADDR_PRST = 2'd1;
   localparam logic [1:0] ADDR_CMD  = 2'd2;
   localparam logic [1:0] ADDR_CTRL = 2'd3;

   localparam logic [1:0] TXC_OFF   = 2'b00;
   localparam logic [1:0] TXC_IRQ   = 2'b01;
   localparam logic [1:0] TXC_NOIRQ = 2'b10;
   localparam logic [1:0] TXC_BRK   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } tx_state_e;

   // Clock cycles per bit for a baud select; select 0 means stopped.
   function automatic logic [CNT_W-1:0] cycles_per_bit(input logic [3:0] sel,
                                                       input int unsigned clk_hz);
      int unsigned cpb;
      case (sel)
         4'd1:    cpb = clk_hz / 32'd50;
         4'd2:    cpb = clk_hz / 32'd75;
         4'd3:    cpb = clk_hz / 32'd110;
         4'd4:    cpb = clk_hz / 32'd135;
         4'd5:    cpb = clk_hz / 32'd150;
         4'd6:    cpb = clk_hz / 32'd300;
         4'd7:    cpb = clk_hz / 32'd600;
         4'd8:    cpb = clk_hz / 32'd1200;
         4'd9:    cpb = clk_hz / 32'd1800;
         4'd10:   cpb = clk_hz / 32'd2400;
         4'd11:   cpb = clk_hz / 32'd3600;
         4'd12:   cpb = clk_hz / 32'd4800;
         4'd13:   cpb = clk_hz / 32'd7200;
         4'd14:   cpb = clk_hz / 32'd9600;
         4'd15:   cpb = clk_hz / 32'd19200;
         default: cpb = 32'd0;
      endcase
      return CNT_W'(cpb);
   endfunction

   // Mask keeping only the bits that are sent for a word-length code.
   function automatic logic [7:0] word_mask(input logic [1:0] wl);
      return 8'hFF >> wl;
   endfunction

endpackage

// File: rtl/acia_baudgen.sv
// Bit-period counter: counts clocks within one bit and flags the last cycle.
module acia_baudgen
   import acia_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic [CNT_W-1:0] period,
   output logic             bit_end_c
);

   logic [CNT_W-1:0] cnt;

   assign bit_end_c = (cnt == period - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset || restart || bit_end_c) cnt <= '0;
      else                               cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/acia_tx.sv
// ACIA transmitter: CPU register file, frame FSM and serial shifter.
module acia_tx
   import acia_pkg::*;
#(
   parameter int unsigned CLK_HZ = 14318180
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic       txd,
   output logic       tdre,
   output logic       tx_irq,
   output logic       rts_n
);

   tx_state_e        state, state_nxt;
   logic [7:0]       tdr, tdr_nxt;
   logic             tdre_nxt;
   logic [7:0]       cmd, cmd_nxt;
   logic [7:0]       ctrl, ctrl_nxt;
   logic [7:0]       shift, shift_nxt;
   logic [1:0]       wlen, wlen_nxt;
   logic             stop2, stop2_nxt;
   logic             par_en, par_en_nxt;
   logic             par_bit, par_bit_nxt;
   logic [CNT_W-1:0] period, period_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic             txd_nxt, tx_irq_nxt, rts_n_nxt;

   logic             load_c, restart_c, bit_end_c;
   logic             baud_on_c, can_load_c, brk_req_c;
   logic [7:0]       tx_data_c;
   logic [2:0]       last_bit_c;
   logic             frame_par_c;
   logic             unused_bits;

   assign baud_on_c  = (ctrl[3:0] != 4'd0);
   assign can_load_c = !tdre && baud_on_c && (cmd[3:2] == TXC_IRQ || cmd[3:2] == TXC_NOIRQ);
   assign brk_req_c  = baud_on_c && (cmd[3:2] == TXC_BRK);
   assign tx_data_c  = tdr & word_mask(ctrl[6:5]);
   assign last_bit_c = 3'd7 - 3'(wlen);
   assign restart_c  = (state_nxt != state) || (state == ST_IDLE) || (state == ST_BREAK);
   assign unused_bits = ^{cmd[4], cmd[1:0], ctrl[4]};

   // Parity over the bits actually sent for the word about to be loaded
   always_comb begin
      case (cmd[7:6])
         2'b00:   frame_par_c = ~^tx_data_c;
         2'b01:   frame_par_c = ^tx_data_c;
         2'b10:   frame_par_c = 1'b1;
         default: frame_par_c = 1'b0;
      endcase
   end

   acia_baudgen u_baudgen (
      .clk       (clk),
      .reset     (reset),
      .restart   (restart_c),
      .period    (period),
      .bit_end_c (bit_end_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         tdr     <= 8'h00;
         tdre    <= 1'b1;
         cmd     <= 8'h00;
         ctrl    <= 8'h00;
         shift   <= 8'h00;
         wlen    <= 2'b00;
         stop2   <= 1'b0;
         par_en  <= 1'b0;
         par_bit <= 1'b0;
         period  <= '0;
         bit_cnt <= 3'd0;
         txd     <= 1'b1;
         tx_irq  <= 1'b0;
         rts_n   <= 1'b1;
      end else begin
         state   <= state_nxt;
         tdr     <= tdr_nxt;
         tdre    <= tdre_nxt;
         cmd     <= cmd_nxt;
         ctrl    <= ctrl_nxt;
         shift   <= shift_nxt;
         wlen    <= wlen_nxt;
         stop2   <= stop2_nxt;
         par_en  <= par_en_nxt;
         par_bit <= par_bit_nxt;
         period  <= period_nxt;
         bit_cnt <= bit_cnt_nxt;
         txd     <= txd_nxt;
         tx_irq  <= tx_irq_nxt;
         rts_n   <= rts_n_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      tdr_nxt     = tdr;
      tdre_nxt    = tdre;
      cmd_nxt     = cmd;
      ctrl_nxt    = ctrl;
      shift_nxt   = shift;
      wlen_nxt    = wlen;
      stop2_nxt   = stop2;
      par_en_nxt  = par_en;
      par_bit_nxt = par_bit;
      period_nxt  = period;
      bit_cnt_nxt = bit_cnt;
      load_c      = 1'b0;
      txd_nxt     = 1'b1;

      case (state)
         ST_IDLE: begin
            if (brk_req_c) begin
               state_nxt  = ST_BREAK;
               period_nxt = cycles_per_bit(ctrl[3:0], CLK_HZ);
            end else if (can_load_c) begin
               load_c = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end_c) begin
               state_nxt   = ST_DATA;
               bit_cnt_nxt = 3'd0;
            end
         end
         ST_DATA: begin
            if (bit_end_c) begin
               if (bit_cnt == last_bit_c) begin
                  state_nxt   = par_en ? ST_PARITY : ST_STOP;
                  bit_cnt_nxt = 3'd0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  shift_nxt   = {1'b0, shift[7:1]};
               end
            end
         end
         ST_PARITY: begin
            if (bit_end_c) begin
               state_nxt   = ST_STOP;
               bit_cnt_nxt = 3'd0;
            end
         end
         ST_STOP: begin
            if (bit_end_c) begin
               if (stop2 && bit_cnt == 3'd0) bit_cnt_nxt = 3'd1;
               else if (can_load_c)          load_c      = 1'b1;
               else                          state_nxt   = ST_IDLE;
            end
         end
         ST_BREAK: begin
            // Leaving break always ends with exactly one stop period
            if (cmd[3:2] != TXC_BRK) begin
               state_nxt   = ST_STOP;
               stop2_nxt   = 1'b0;
               bit_cnt_nxt = 3'd0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (load_c) begin
         state_nxt   = ST_START;
         tdre_nxt    = 1'b1;
         shift_nxt   = tx_data_c;
         wlen_nxt    = ctrl[6:5];
         stop2_nxt   = ctrl[7];
         par_en_nxt  = cmd[5];
         par_bit_nxt = frame_par_c;
         period_nxt  = cycles_per_bit(ctrl[3:0], CLK_HZ);
         bit_cnt_nxt = 3'd0;
      end

      // CPU writes win over the load-cycle tdre set
      if (cs && we) begin
         case (addr)
            ADDR_TDR: begin
               tdr_nxt  = din;
               tdre_nxt = 1'b0;
            end
            ADDR_CMD:  cmd_nxt  = din;
            ADDR_CTRL: ctrl_nxt = din;
            ADDR_PRST: begin
               state_nxt    = ST_IDLE;
               tdre_nxt     = 1'b1;
               cmd_nxt[4:0] = 5'd0;
               bit_cnt_nxt  = 3'd0;
            end
            default: ;
         endcase
      end

      case (state_nxt)
         ST_START:  txd_nxt = 1'b0;
         ST_DATA:   txd_nxt = shift_nxt[0];
         ST_PARITY: txd_nxt = par_bit_nxt;
         ST_BREAK:  txd_nxt = 1'b0;
         default:   txd_nxt = 1'b1;
      endcase

      tx_irq_nxt = tdre_nxt && (cmd_nxt[3:2] == TXC_IRQ);
      rts_n_nxt  = (cmd_nxt[3:2] == TXC_OFF);
   end

endmodule

// File: tb/tb_acia_tx.sv
// Directed bench for acia_tx: table of frames plus hand-written IRQ, overwrite,
// programmed-reset, break, stopped-baud and hard-reset sequences.
module tb_acia_tx;

   localparam int unsigned CLK_HZ = 1920000;

   logic       clk = 1'b0;
   logic       reset;
   logic       cs;
   logic       we;
   logic [1:0] addr;
   logic [7:0] din;
   logic       txd;
   logic       tdre;
   logic       tx_irq;
   logic       rts_n;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [7:0]  ctrl;
      logic [7:0]  cmd;
      logic [7:0]  data;
      logic [11:0] bits;
      int          n;
   } vec_t;

   vec_t vecs[5];

   acia_tx #(.CLK_HZ(CLK_HZ)) dut (
      .clk    (clk),
      .reset  (reset),
      .cs     (cs),
      .we     (we),
      .addr   (addr),
      .din    (din),
      .txd    (txd),
      .tdre   (tdre),
      .tx_irq (tx_irq),
      .rts_n  (rts_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(posedge clk);
      #1;
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;

      // bits[k] is the k-th bit on the line, start bit first
      vecs[0] = '{ctrl: 8'h0F, cmd: 8'h08, data: 8'h55, bits: 12'h2AA, n: 10};
      vecs[1] = '{ctrl: 8'h2F, cmd: 8'h68, data: 8'h41, bits: 12'h282, n: 10};
      vecs[2] = '{ctrl: 8'h6F, cmd: 8'h28, data: 8'h13, bits: 12'h0A6, n: 8};
      vecs[3] = '{ctrl: 8'hCF, cmd: 8'hA8, data: 8'h2A, bits: 12'h3D4, n: 10};
      vecs[4] = '{ctrl: 8'h0F, cmd: 8'hE8, data: 8'h80, bits: 12'h500, n: 11};

      reset = 1'b1; cs = 1'b0; we = 1'b0; addr = 2'd0; din = 8'h00;
      wait_cyc(3);
      check("rst_txd", txd, 1);
      check("rst_tdre", tdre, 1);
      check("rst_irq", tx_irq, 0);
      check("rst_rts_n", rts_n, 1);
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(2);

      // Table-driven frames, each bit checked on its first and last cycle
      for (int i = 0; i < 5; i++) begin
         wr(2'd3, vecs[i].ctrl);
         wr(2'd2, vecs[i].cmd);
         wr(2'd0, vecs[i].data);
         check($sformatf("v%0d_tdre_written", i), tdre, 0);
         wait_cyc(1);
         check($sformatf("v%0d_tdre_loaded", i), tdre, 1);
         check($sformatf("v%0d_rts_n", i), rts_n, 0);
         for (int k = 0; k < vecs[i].n; k++) begin
            check($sformatf("v%0d_bit%0d_head", i, k), txd, vecs[i].bits[k]);
            wait_cyc(99);
            check($sformatf("v%0d_bit%0d_tail", i, k), txd, vecs[i].bits[k]);
            wait_cyc(1);
         end
         check($sformatf("v%0d_idle", i), txd, 1);
         wait_cyc(5);
      end

      // IRQ toggling and back-to-back frames
      wr(2'd3, 8'h0F);
      wr(2'd2, 8'h04);
      check("irq_idle", tx_irq, 1);
      wr(2'd0, 8'hA5);
      check("irq_written", tx_irq, 0);
      wait_cyc(1);
      check("irq_loaded", tx_irq, 1);
      check("irq_start", txd, 0);
      wait_cyc(199);
      wr(2'd0, 8'h3C);
      check("irq_second_write", tx_irq, 0);
      check("irq_second_tdre", tdre, 0);
      wait_cyc(799);
      check("b2b_stop", txd, 1);
      wait_cyc(1);
      check("b2b_start", txd, 0);
      check("b2b_irq", tx_irq, 1);
      check("b2b_tdre", tdre, 1);
      wait_cyc(150);
      check("b2b_d0", txd, 0);
      wait_cyc(200);
      check("b2b_d2", txd, 1);
      wait_cyc(700);
      check("b2b_idle", txd, 1);

      // Write in the load cycle, then programmed reset mid-DATA
      wr(2'd2, 8'h08);
      wr(2'd0, 8'h0F);
      wr(2'd0, 8'hF0);
      check("ovw_start", txd, 0);
      check("ovw_tdre", tdre, 0);
      wait_cyc(100);
      check("ovw_first_d0", txd, 1);
      wait_cyc(900);
      check("ovw_second_start", txd, 0);
      check("ovw_second_tdre", tdre, 1);
      wait_cyc(100);
      check("ovw_second_d0", txd, 0);
      wait_cyc(150);
      wr(2'd1, 8'h00);
      check("prst_txd", txd, 1);
      check("prst_tdre", tdre, 1);
      check("prst_rts_n", rts_n, 1);
      check("prst_irq", tx_irq, 0);
      wr(2'd0, 8'h99);
      wait_cyc(20);
      check("prst_disabled_txd", txd, 1);
      check("prst_disabled_tdre", tdre, 0);

      // Break from idle, then one stop period and back to idle
      wr(2'd1, 8'h00);
      wr(2'd2, 8'h0C);
      check("brk_rts_n", rts_n, 0);
      wait_cyc(1);
      check("brk_enter", txd, 0);
      wait_cyc(250);
      check("brk_mid", txd, 0);
      wait_cyc(249);
      check("brk_late", txd, 0);
      wr(2'd2, 8'h08);
      wait_cyc(1);
      check("brk_stop_head", txd, 1);
      wait_cyc(99);
      check("brk_stop_tail", txd, 1);
      wr(2'd0, 8'h00);
      check("brk_idle_line", txd, 1);
      wait_cyc(1);
      check("brk_idle_then_start", txd, 0);
      wait_cyc(1000);
      check("brk_frame_done", txd, 1);

      // Baud select 0 must never start a frame
      wr(2'd3, 8'h00);
      wr(2'd0, 8'h5A);
      lows = 0;
      for (int c = 0; c < 10000; c++) begin
         wait_cyc(1);
         if (!txd) lows++;
      end
      check("baud0_low_cycles", 32'(lows), 0);
      check("baud0_tdre", tdre, 0);

      // Hard reset in the middle of a frame
      wr(2'd3, 8'h0F);
      wait_cyc(1);
      check("hrst_pre_start", txd, 0);
      wait_cyc(150);
      check("hrst_pre_d0", txd, 0);
      @(negedge clk);
      reset = 1'b1;
      wait_cyc(1);
      check("hrst_txd", txd, 1);
      check("hrst_tdre", tdre, 1);
      check("hrst_irq", tx_irq, 0);
      check("hrst_rts_n", rts_n, 1);
      @(negedge clk);
      reset = 1'b0;
      wr(2'd3, 8'h0F);
      wr(2'd2, 8'h08);
      wait_cyc(200);
      check("hrst_after_txd", txd, 1);
      check("hrst_after_tdre", tdre, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
